// File: rtl/ddr_port0_writer.sv
// ddr_port0_writer
// Frame-buffer write stage of the Mandelbrot pipeline. It takes per-pixel
// iteration counts in raster order and maps each one to a 24-bit colour. The
// colours go into the MCB port-0 write FIFO, and the block issues write bursts
// of up to MAX_BURST words.
// Layout matches the port-1 reader:
//   byte address = BASE_ADDR + 4*(y*x_size + x), one pixel per 32-bit word.
//
// Build option: COLOR_MAP_EN
//   defined   -> palette R = iter, G = {iter[5:0],2'b00}, B = ~iter
//   undefined -> greyscale R = G = B = iter
//   In both builds, MAX_ITERATIONS maps to black.
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid && pix_ready.
// pix_ready is combinational from state, wr_full, word_cnt and pix_sof. It never
// depends on pix_valid. The producer holds pix_sof/pix_iter stable while
// pix_valid is high and the pixel has not yet transferred.
// The MCB side has no ready. wr_en is asserted only while wr_full was low at
// accept time. cmd_en is a one-cycle pulse issued only when cmd_full is low.
// The debug output dbg_state exposes the FSM state:
//   0 = WAIT_CAL, 1 = FILL, 2 = FLUSH, 3 = CMD.

module ddr_port0_writer #(
  parameter int          MAX_ITERATIONS = 255,
  parameter logic [29:0] BASE_ADDR      = 30'd5242880,
  parameter int          MAX_BURST      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [10:0] x_size,
  input  logic [10:0] y_size,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [7:0]  pix_iter,
  output logic        pix_ready,
  input  logic        wr_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        cmd_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  localparam logic [6:0] BURST_WORDS = 7'(MAX_BURST);
  localparam logic [7:0] ITER_BLACK  = 8'(MAX_ITERATIONS);

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    FILL     = 2'd1,
    FLUSH    = 2'd2,
    CMD      = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Calibration synchroniser.
  logic cal_s1;
  logic cal_s2;

  // Burst and raster bookkeeping.
  logic [6:0]  word_cnt;
  logic [10:0] x;
  logic [10:0] y;
  logic [20:0] line_base;
  logic [29:0] burst_addr;
  logic        frame_end_pend;

  // Combinational helpers.
  logic        accept;
  logic        cmd_issue;
  logic        sof_flush;
  logic [10:0] x_eff;
  logic [10:0] y_eff;
  logic [20:0] lb_eff;
  logic [10:0] x_inc;
  logic [10:0] y_inc;
  logic        eol;
  logic        last_line;
  logic        burst_end;
  logic [21:0] pix_index;
  logic [29:0] pix_addr;
  logic [6:0]  bl_full;
  logic [23:0] colour;

  // Map an iteration count to a 24-bit RGB value.
  function automatic logic [23:0] colour_of(input logic [7:0] it);
    logic [23:0] c;
    if (it == ITER_BLACK) begin
      c = 24'h000000;
    end else begin
`ifdef COLOR_MAP_EN
      c = {it, it[5:0], 2'b00, ~it};
`else
      c = {it, it, it};
`endif
    end
    return c;
  endfunction

  assign dbg_state = state;
  assign wr_mask   = 4'b0000;
  assign cmd_instr = 3'b000;

  // Two-flop synchroniser for the asynchronous calibration flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_s1 <= 1'b0;
      cal_s2 <= 1'b0;
    end else begin
      cal_s1 <= mem_calib_done;
      cal_s2 <= cal_s1;
    end
  end

  // Raster position of the offered pixel: a start-of-frame pixel restarts at (0,0).
  always_comb begin
    x_eff     = pix_sof ? 11'd0 : x;
    y_eff     = pix_sof ? 11'd0 : y;
    lb_eff    = pix_sof ? 21'd0 : line_base;
    x_inc     = x_eff + 11'd1;
    y_inc     = y_eff + 11'd1;
    eol       = (x_inc == x_size);
    last_line = (y_inc == y_size);
    burst_end = ((word_cnt + 7'd1) == BURST_WORDS) || eol;
    pix_index = {1'b0, lb_eff} + {11'd0, x_eff};
    pix_addr  = BASE_ADDR + {6'd0, pix_index, 2'b00};
    bl_full   = word_cnt - 7'd1;
    colour    = colour_of(pix_iter);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_CAL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_CAL: begin
        // Calibration dropping later is ignored: WAIT_CAL is never re-entered.
        if (cal_s2) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if ((accept && burst_end) || sof_flush || (word_cnt >= BURST_WORDS)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // One idle cycle lets the final wr_en land before the command.
        state_nxt = CMD;
      end
      CMD: begin
        if (!cmd_full) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = WAIT_CAL;
    endcase
  end

  // FSM outputs: pixel handshake and command issue strobe.
  always_comb begin
    pix_ready = (state == FILL) && !wr_full && (word_cnt < BURST_WORDS) &&
                !(pix_sof && (word_cnt != 7'd0));
    accept    = pix_valid && pix_ready;
    // A new frame with a partial burst pending flushes that burst first.
    sof_flush = (state == FILL) && pix_valid && pix_sof && (word_cnt != 7'd0);
    cmd_issue = (state == CMD) && !cmd_full;
  end

  // Write-FIFO side: register the colour word and push it one cycle after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_data <= 32'h0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_data <= {8'h00, colour};
      end
    end
  end

  // Command side: issue the burst and mark the end of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_en        <= 1'b0;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= 30'd0;
      frame_done    <= 1'b0;
    end else begin
      cmd_en     <= cmd_issue;
      frame_done <= cmd_issue && frame_end_pend;
      if (cmd_issue) begin
        cmd_bl        <= bl_full[5:0];
        cmd_byte_addr <= burst_addr;
      end
    end
  end

  // Burst word count and start address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt   <= 7'd0;
      burst_addr <= 30'd0;
    end else begin
      if (cmd_issue) begin
        word_cnt <= 7'd0;
      end else if (accept) begin
        word_cnt <= word_cnt + 7'd1;
        if (word_cnt == 7'd0) begin
          burst_addr <= pix_addr;
        end
      end
    end
  end

  // Raster counters: line_base accumulates x_size per line instead of multiplying.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x              <= 11'd0;
      y              <= 11'd0;
      line_base      <= 21'd0;
      frame_end_pend <= 1'b0;
    end else begin
      if (cmd_issue) begin
        frame_end_pend <= 1'b0;
      end
      if (accept) begin
        if (eol) begin
          x <= 11'd0;
          if (last_line) begin
            y              <= 11'd0;
            line_base      <= 21'd0;
            frame_end_pend <= 1'b1;
          end else begin
            y         <= y_inc;
            line_base <= lb_eff + {10'd0, x_size};
          end
        end else begin
          x         <= x_inc;
          y         <= y_eff;
          line_base <= lb_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_port0_writer.sv
// Testbench for ddr_port0_writer.
// The driver pushes expected write words and commands into queues as it
// offers pixels. A negedge monitor pops and compares them against the DUT.
// Directed steps cover the following:
//   - reset values;
//   - the calibration gate;
//   - back-pressure on both FIFOs;
//   - colours;
//   - end-of-line bursts;
//   - early start-of-frame.

module tb_ddr_port0_writer;

  localparam logic [29:0] BASE = 30'd5242880;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_calib_done;
  logic [10:0] x_size;
  logic [10:0] y_size;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_iter;
  logic        pix_ready;
  logic        wr_full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        cmd_full;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        frame_done;
  logic [1:0]  dbg_state;

  ddr_port0_writer dut (
    .clk           (clk),
    .reset         (reset),
    .mem_calib_done(mem_calib_done),
    .x_size        (x_size),
    .y_size        (y_size),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_iter      (pix_iter),
    .pix_ready     (pix_ready),
    .wr_full       (wr_full),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .cmd_full      (cmd_full),
    .cmd_en        (cmd_en),
    .cmd_instr     (cmd_instr),
    .cmd_bl        (cmd_bl),
    .cmd_byte_addr (cmd_byte_addr),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Counters and scoreboard state.
  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_data_q[$];
  logic [36:0] exp_cmd_q[$];   // {frame_done, bl[5:0], addr[29:0]}

  int          m_x = 0;
  int          m_y = 0;
  int          m_wc = 0;
  int          xs = 640;
  int          ys = 4;
  logic [29:0] m_addr = 30'd0;

  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          last_gap = 0;
  int          cmd_n = 0;
  int          fd_n = 0;
  int          last_waits = 0;
  logic [29:0] log_addr [0:511];
  logic [5:0]  log_bl [0:511];
  logic [31:0] mon_w;
  logic [36:0] mon_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] colour_model(input logic [7:0] it);
    logic [31:0] c;
    if (it == 8'd255) c = 32'h0;
`ifdef COLOR_MAP_EN
    else c = {8'h00, it, it[5:0], 2'b00, ~it};
`else
    else c = {8'h00, it, it, it};
`endif
    return c;
  endfunction

  function automatic logic [7:0] rand_iter();
    if ($urandom_range(0, 9) == 0) return 8'd255;
    return 8'($urandom_range(0, 254));
  endfunction

  // Offer one pixel (called at a negedge); returns at the negedge after acceptance.
  task automatic send_pix(input logic sof, input logic [7:0] it);
    logic acc;
    int   waits;
    if (sof && m_wc != 0) begin
      exp_cmd_q.push_back({1'b0, 6'(m_wc - 1), m_addr});
      m_wc = 0;
    end
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_iter  = it;
    acc   = 1'b0;
    waits = 0;
    while (!acc && waits < 200) begin
      #1;
      acc = pix_ready;
      @(posedge clk);
      if (!acc) waits++;
    end
    last_waits = waits;
    if (!acc) begin
      chk("accept_timeout", 32'(acc), 32'd1);
    end else begin
      if (sof) begin
        m_x = 0;
        m_y = 0;
      end
      if (m_wc == 0) m_addr = BASE + 30'(4 * (m_y * xs + m_x));
      exp_data_q.push_back(colour_model(it));
      m_wc++;
      m_x++;
      if (m_wc == 64 || m_x == xs) begin
        exp_cmd_q.push_back({((m_x == xs) && (m_y + 1 == ys)), 6'(m_wc - 1), m_addr});
        m_wc = 0;
        if (m_x == xs) begin
          m_x = 0;
          m_y = (m_y + 1 == ys) ? 0 : m_y + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) send_pix(1'b0, rand_iter());
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_cmd_q.size() != 0 || exp_data_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_drain"}, 32'(exp_cmd_q.size() + exp_data_q.size()), 32'd0);
  endtask

  // Monitor: pop and compare write words and commands on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (wr_en) begin
        last_wr_cyc = cyc;
        if (exp_data_q.size() == 0) begin
          chk("wr_unexpected_q_size", 32'(exp_data_q.size()), 32'd1);
        end else begin
          mon_w = exp_data_q.pop_front();
          chk("wr_data", wr_data, mon_w);
        end
        chk("wr_mask", 32'(wr_mask), 32'd0);
      end
      if (cmd_en) begin
        last_gap = cyc - last_wr_cyc;
        if (cmd_n < 512) begin
          log_addr[cmd_n] = cmd_byte_addr;
          log_bl[cmd_n]   = cmd_bl;
        end
        cmd_n++;
        if (frame_done) fd_n++;
        if (exp_cmd_q.size() == 0) begin
          chk("cmd_unexpected_q_size", 32'(exp_cmd_q.size()), 32'd1);
        end else begin
          mon_c = exp_cmd_q.pop_front();
          chk("cmd_bl", 32'(cmd_bl), 32'(mon_c[35:30]));
          chk("cmd_addr", 32'(cmd_byte_addr), 32'(mon_c[29:0]));
          chk("cmd_frame_done", 32'(frame_done), 32'(mon_c[36]));
        end
        chk("cmd_instr", 32'(cmd_instr), 32'd0);
      end else if (frame_done) begin
        chk("frame_done_stray", 32'(frame_done), 32'd0);
      end
    end
  end

  int          start_n;
  int          start_fd;
  logic [29:0] snap_addr;
  logic [5:0]  snap_bl;
  logic [31:0] col12;

  // Directed stimulus sequence.
  initial begin
    reset = 1'b1; mem_calib_done = 1'b0; x_size = 11'd640; y_size = 11'd4;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_iter = 8'h00; wr_full = 1'b0; cmd_full = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_mask", 32'(wr_mask), 32'd0);
    chk("rst_cmd_en", 32'(cmd_en), 32'd0);
    chk("rst_cmd_instr", 32'(cmd_instr), 32'd0);
    chk("rst_cmd_bl", 32'(cmd_bl), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_byte_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Calibration gate: no acceptance while calib is low.
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = 1'b1; pix_iter = 8'h12;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("cal_gate_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
    end
    mem_calib_done = 1'b1;

    // Frame A (640x4): first burst with a wr_full stall.
    start_n = cmd_n; start_fd = fd_n;
    send_pix(1'b1, 8'h12);
    chk("cal_latency_le3", 32'(last_waits <= 3), 32'd1);
    send_run(19);
    wr_full = 1'b1; pix_sof = 1'b0; pix_iter = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wrfull_ready_low", 32'(pix_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("wrfull_no_wr_en", 32'(wr_en), 32'd0);
    end
    wr_full = 1'b0;
    send_run(44);
    pix_valid = 1'b0;
    drain("burst1");
    chk("burst1_gap", 32'(last_gap), 32'd2);
    chk("burst1_bl", 32'(log_bl[start_n]), 32'd63);
    chk("burst1_addr", 32'(log_addr[start_n]), 32'(BASE));

    // Second burst held off by cmd_full for 10 cycles.
    cmd_full = 1'b1;
    send_run(64);
    pix_valid = 1'b0;
    snap_addr = cmd_byte_addr;
    snap_bl   = cmd_bl;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cmdfull_no_cmd_en", 32'(cmd_en), 32'd0);
      chk("cmdfull_addr_hold", 32'(cmd_byte_addr), 32'(snap_addr));
      chk("cmdfull_bl_hold", 32'(cmd_bl), 32'(snap_bl));
    end
    cmd_full = 1'b0;
    drain("burst2");
    chk("burst2_addr", 32'(log_addr[start_n + 1]), 32'(BASE + 30'd256));

    // Rest of frame A.
    send_run(640 * 4 - 128);
    pix_valid = 1'b0;
    drain("frameA");
    chk("frameA_cmds", 32'(cmd_n - start_n), 32'd40);
    chk("frameA_frame_done", 32'(fd_n - start_fd), 32'd1);
    chk("frameA_line1_addr", 32'(log_addr[start_n + 10]), 32'(BASE + 30'd2560));
    chk("frameA_bl_last_line0", 32'(log_bl[start_n + 9]), 32'd63);

    // Frame B (800x2): colours and a 32-word tail burst per line.
    x_size = 11'd800; y_size = 11'd2; xs = 800; ys = 2;
    start_n = cmd_n; start_fd = fd_n;
    send_pix(1'b1, 8'hFF);
    chk("lat_wr_en", 32'(wr_en), 32'd1);
    chk("col_255", wr_data, 32'h0000_0000);
`ifdef COLOR_MAP_EN
    col12 = 32'h0012_48ED;
`else
    col12 = 32'h0012_1212;
`endif
    send_pix(1'b0, 8'h12);
    chk("col_12", wr_data, col12);
    send_run(1598);
    pix_valid = 1'b0;
    drain("frameB");
    chk("frameB_cmds", 32'(cmd_n - start_n), 32'd26);
    chk("frameB_tail_bl", 32'(log_bl[start_n + 12]), 32'd31);
    chk("frameB_tail_addr", 32'(log_addr[start_n + 12]), 32'(BASE + 30'd3072));
    chk("frameB_line1_addr", 32'(log_addr[start_n + 13]), 32'(BASE + 30'd3200));
    chk("frameB_frame_done", 32'(fd_n - start_fd), 32'd1);

    // Frame C (640x4): early sof after 10 pixels of line 3.
    x_size = 11'd640; y_size = 11'd4; xs = 640; ys = 4;
    start_n = cmd_n; start_fd = fd_n;
    send_pix(1'b1, rand_iter());
    send_run(640 * 3 - 1 + 10);
    send_pix(1'b1, rand_iter());
    send_run(63);
    pix_valid = 1'b0;
    drain("frameC");
    chk("early_sof_cmds", 32'(cmd_n - start_n), 32'd32);
    chk("early_sof_bl", 32'(log_bl[start_n + 30]), 32'd9);
    chk("early_sof_addr", 32'(log_addr[start_n + 30]), 32'(BASE + 30'd7680));
    chk("early_sof_next_addr", 32'(log_addr[start_n + 31]), 32'(BASE));
    chk("early_sof_next_bl", 32'(log_bl[start_n + 31]), 32'd63);
    chk("early_sof_no_frame_done", 32'(fd_n - start_fd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
